// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - data-memory responder: byte-writable RAM, console TX FIFO, cycle counter
// Optional 64-bit cycle counter is built only when DMEM_CYCLE_CNT_EN is defined.
module dmem_resp #(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);
  localparam int unsigned AW = $clog2(DepthWords);
  localparam int unsigned FW = $clog2(FifoDepth);
  localparam logic [FW:0] FULL_CNT = (FW+1)'(FifoDepth);

  logic          is_io;
  logic [AW-1:0] ram_idx;
  logic [1:0]    io_sel;
  logic [31:0]   mem [DepthWords];

  logic [7:0]    fifo_mem [FifoDepth];
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr;
  logic [FW:0]   count;
  logic          ovf;
  logic          full;
  logic          empty;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          ovf_clr;
  logic [63:0]   cycle;
  logic          unused_addr;

  assign is_io   = d_addr[31];
  assign ram_idx = d_addr[AW+1:2];
  assign io_sel  = d_addr[3:2];

  // Bits [30:AW+2] only alias RAM/IO and [1:0] are byte offsets within a word.
  assign unused_addr = ^{d_addr[30:AW+2], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (d_wstrb[i]) mem[ram_idx][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  assign push    = is_io && (io_sel == 2'd0) && d_wstrb[0];
  assign push_ok = push && !full;
  assign pop     = con_valid && con_ready;
  assign ovf_clr = is_io && (io_sel == 2'd1) && d_wstrb[0] && d_wdata[2];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= d_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FW'(1);
      if (pop)     rd_ptr <= rd_ptr + FW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FW+1)'(1);
        2'b01:   count <= count - (FW+1)'(1);
        default: count <= count;
      endcase
      // A push against a full FIFO is dropped even when a pop frees a slot this edge.
      if (push && full) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef DMEM_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle <= '0;
    else        cycle <= cycle + 64'd1;
  end
`else
  assign cycle = '0;
`endif

  always_comb begin
    d_rdata = '0;
    if (!is_io) begin
      d_rdata = mem[ram_idx];
    end else begin
      case (io_sel)
        2'd0:    d_rdata = 32'(count);
        2'd1:    d_rdata = {29'b0, ovf, empty, full};
        2'd2:    d_rdata = cycle[31:0];
        default: d_rdata = cycle[63:32];
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - directed self-checking bench for dmem_resp
module tb_dmem_resp;
  logic        clk;
  logic        reset;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] CON_TX   = 32'h8000_0000;
  localparam logic [31:0] STATUS   = 32'h8000_0004;
  localparam logic [31:0] CYCLE_LO = 32'h8000_0008;

  dmem_resp #(.DepthWords(1024), .FifoDepth(8)) dut (
    .clk(clk), .reset(reset), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    d_addr = a; d_wdata = d; d_wstrb = s;
    @(posedge clk);
    #1;
    d_wstrb = 4'b0000;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    d_addr = a; d_wstrb = 4'b0000;
    #1;
    check(tag, 64'(d_rdata), 64'(exp));
  endtask

  logic [7:0] drain_exp [4];
  logic       drain_rdy [4];
  logic [31:0] cyc_exp;

  initial begin
    drain_exp[0] = 8'h41; drain_exp[1] = 8'h42; drain_exp[2] = 8'h42; drain_exp[3] = 8'h43;
    drain_rdy[0] = 1'b1;  drain_rdy[1] = 1'b0;  drain_rdy[2] = 1'b1;  drain_rdy[3] = 1'b1;
`ifdef DMEM_CYCLE_CNT_EN
    cyc_exp = 32'd100;
`else
    cyc_exp = 32'd0;
`endif
    reset = 1'b0; d_addr = STATUS; d_wdata = '0; d_wstrb = '0; con_ready = 1'b0;
    repeat (3) @(posedge clk);

    // reset state
    rd("rst_status", STATUS, 32'b010);
    rd("rst_count", CON_TX, 32'd0);
    check("rst_valid", 64'(con_valid), 64'd0);
    check("rst_data", 64'(con_data), 64'h00);

    // cycle counter after 100 edges out of reset
    @(negedge clk);
    d_addr = CYCLE_LO;
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("cycle_lo_100", 64'(d_rdata), 64'(cyc_exp));

    // RAM byte strobes and aliasing
    wr(32'h10, 32'hDEADBEEF, 4'b1111);
    wr(32'h10, 32'h000000AA, 4'b0001);
    rd("ram_strobe", 32'h10, 32'hDEADBEAA);
    rd("ram_alias", 32'h1010, 32'hDEADBEAA);
    wr(32'h13, 32'h5500_0000, 4'b1000);
    rd("ram_lane3", 32'h10, 32'h55ADBEAA);

    // IO write to an aliased address leaves RAM alone
    wr(32'h18, 32'h11111111, 4'b1111);
    wr(32'h8000_0018, 32'h12345678, 4'b1111);
    rd("io_no_ram", 32'h18, 32'h11111111);

    // same-cycle read during write
    wr(32'h20, 32'h1, 4'b1111);
    @(negedge clk);
    d_addr = 32'h20; d_wdata = 32'h2; d_wstrb = 4'b1111;
    #1;
    check("rdw_old", 64'(d_rdata), 64'h1);
    @(posedge clk);
    #1;
    d_wstrb = 4'b0000;
    check("rdw_new", 64'(d_rdata), 64'h2);

    // fill FIFO past capacity with no drain
    for (int i = 0; i < 9; i++) wr(CON_TX, 32'h41 + i, 4'b0001);
    rd("fill_status", STATUS, 32'b101);
    rd("fill_count", CON_TX, 32'd8);
    check("fill_head", 64'(con_data), 64'h41);
    wr(STATUS, 32'h4, 4'b0001);
    rd("w1c_status", STATUS, 32'b001);

    // full FIFO: push and pop on the same edge, push is dropped
    @(negedge clk);
    d_addr = CON_TX; d_wdata = 32'h5A; d_wstrb = 4'b0001; con_ready = 1'b1;
    @(posedge clk);
    #1;
    d_wstrb = 4'b0000; con_ready = 1'b0;
    rd("fullpp_status", STATUS, 32'b100);
    rd("fullpp_count", CON_TX, 32'd7);
    check("fullpp_head", 64'(con_data), 64'h42);

    // drain remaining 0x42..0x48, 0x49 and 0x5A never arrive
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      con_ready = 1'b1;
      #1;
      check("drain_all", 64'(con_data), 64'(8'h42 + i));
    end
    @(negedge clk);
    con_ready = 1'b0;
    #1;
    check("drain_empty_valid", 64'(con_valid), 64'd0);
    check("drain_empty_data", 64'(con_data), 64'h00);
    wr(STATUS, 32'h4, 4'b0001);

    // drain with backpressure
    for (int i = 0; i < 3; i++) wr(CON_TX, 32'h41 + i, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      con_ready = drain_rdy[i];
      #1;
      check("bp_data", 64'(con_data), 64'(drain_exp[i]));
    end
    @(negedge clk);
    con_ready = 1'b0;
    #1;
    check("bp_valid_end", 64'(con_valid), 64'd0);
    check("bp_data_end", 64'(con_data), 64'h00);

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) wr(CON_TX, 32'h61 + i, 4'b0001);
    @(negedge clk);
    con_ready = 1'b1;
    @(posedge clk);
    #2;
    check("mid_valid_pre", 64'(con_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_valid_rst", 64'(con_valid), 64'd0);
    check("mid_data_rst", 64'(con_data), 64'h00);
    con_ready = 1'b0;
    rd("mid_count_rst", CON_TX, 32'd0);
    rd("ram_kept", 32'h10, 32'h55ADBEAA);
    @(negedge clk);
    reset = 1'b1;
    rd("post_status", STATUS, 32'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the single-cycle RISC-V core. It serves the core's `d_addr`/`d_wdata`/`d_wstrb`/`d_rdata` port as the memory-side end of that interface. It holds a word-organised, byte-writable RAM, a buffered console transmit channel with a valid/ready drain port, and a free-running 64-bit cycle counter. Reads are combinational, so a load completes in the same cycle. Writes commit on the rising clock edge.

## Interface
- `DepthWords`, 1024: RAM size in 32-bit words; power of two, ≥4.
- `FifoDepth`, 8: console FIFO entries; power of two, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `d_addr`  in  32  byte address; `[1:0]` ignored.
- `d_wdata`  in  32  write data, lane-aligned.
- `d_wstrb`  in  4  byte write strobes; `4'b0000` means no write.
- `d_rdata`  out  32  read data, combinational from `d_addr`.
- `con_data`  out  8  FIFO head byte; `8'h00` when empty.
- `con_valid`  out  1  FIFO non-empty.
- `con_ready`  in  1  console sink accepts `con_data` this cycle.

## Operation
- Decode on `d_addr[31]`: 0 selects RAM, 1 selects IO.
- RAM word index is `d_addr[log2(DepthWords)+1:2]`. Upper address bits are ignored, so the RAM aliases and wraps.
- RAM write: at the clock edge, each byte lane `i` with `d_wstrb[i]=1` takes `d_wdata[8i+7:8i]`. Other lanes are unchanged.
- RAM read is asynchronous. A same-cycle read of a word being written returns the pre-write value.
- RAM contents are not reset.
- IO registers are selected by `d_addr[3:2]`. Bits `[30:4]` are ignored, so the registers alias.
  - 0x0 `CON_TX`: a write with `d_wstrb[0]=1` pushes `d_wdata[7:0]`. Read returns `{24'b0, count}`, with count zero-extended.
  - 0x4 `STATUS`: read returns `{29'b0, ovf, empty, full}`. A write with `d_wstrb[0]=1` and `d_wdata[2]=1` clears `ovf` (W1C). Other bits are read-only.
  - 0x8 `CYCLE_LO`: read returns `cycle[31:0]`. Writes are ignored.
  - 0xC `CYCLE_HI`: read returns `cycle[63:32]`. Writes are ignored; software handles rollover by re-reading.
- A write to IO never touches RAM, and the reverse also holds.
- Console FIFO:
  - Circular buffer with read/write pointers and a count of width `log2(FifoDepth)+1`.
  - Push when full, judged on the registered `full`: the byte is dropped and `ovf` is set, even if a pop occurs the same cycle.
  - Push when not full stores the byte at the write pointer and increments the pointer modulo `FifoDepth`.
  - Pop occurs when `con_valid & con_ready` at the edge.
  - Push and pop in the same cycle on a non-empty, non-full FIFO leaves count unchanged.
  - Push into an empty FIFO: no pop that cycle. `con_valid` rises the next cycle.
  - `con_data` and `con_valid` must hold stable while `con_valid=1` and `con_ready=0`.
- Cycle counter: 64-bit, increments every cycle, wraps from `2^64-1` to 0.

## Timing
- Reset values:
  - FIFO empty, pointers 0, `ovf`=0.
  - `con_valid`=0, `con_data`=`8'h00`.
  - cycle = 0.
  - `d_rdata` for an IO address reflects these values immediately. For a RAM address it is undefined until written.
- Reset asserted mid-operation discards FIFO contents and `ovf` asynchronously. RAM is kept.
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- After a push, `con_valid`, `count` and `STATUS` update the next cycle.
- A cycle read returns the counter value before this cycle's increment.

## Configuration
- `DMEM_CYCLE_CNT_EN` defined: the 64-bit counter is built as above.
- `DMEM_CYCLE_CNT_EN` undefined: no counter flops. `CYCLE_LO` and `CYCLE_HI` read `32'h0`. Writes to them remain ignored.

## Test plan
- RAM byte strobes:
  - Stimulus: write `0xDEADBEEF` to 0x10 with strobe `4'b1111`, then `0x000000AA` with strobe `4'b0001`.
  - Required: read 0x10 returns `0xDEADBEAA`. Read `0x10+4*DepthWords` returns the same word (aliasing).
- Same-cycle read-during-write:
  - Stimulus: drive 0x20 holding 0x1 with `d_wdata`=0x2 and strobe `4'b1111`.
  - Required: `d_rdata`=0x1 that cycle and 0x2 the next.
- FIFO fill/overflow:
  - Stimulus: with `con_ready`=0, push 9 bytes 0x41..0x49 (`FifoDepth`=8).
  - Required: `STATUS`=0b101, `CON_TX` reads 8, 0x49 is lost.
  - Then write `STATUS` with 0x4. Required: `STATUS`=0b001.
- Drain with backpressure:
  - Stimulus: with 3 bytes queued, toggle `con_ready` 1,0,1,1.
  - Required: `con_data` shows 0x41, 0x42 (held during the stall), 0x42, 0x43. Then `con_valid`=0 and `con_data`=0x00.
- Full push+pop same cycle:
  - Stimulus: with the FIFO full, `con_ready`=1 and a push of 0x5A.
  - Required: the byte is dropped, `ovf`=1, count=7.
- Reset and counter:
  - Stimulus: deassert `reset`, wait 100 cycles, read `CYCLE_LO`.
  - Required: reads 100 (0 with the macro undefined).
  - Stimulus: assert `reset` mid-drain.
  - Required: `con_valid`=0 immediately, without waiting for a clock edge.
